pc_branch_unit: RTL

Program-counter owner and branch-redirect controller for the 16-bit CPU. It consumes the branch decision from the ID-stage comparator (`branch`), computes the branch or jump target, and redirects fetch. It also squashes wrong-path instructions with a counted flush and handles stall and halt. It sits between the ID-stage comparator/decoder and the IF stage's instruction-memory address port.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/branch_target_calc.sv | 25 ++
 rtl/pc_branch_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the 16-bit CPU pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int INSTR_BYTES = 2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } pc_state_t;

    // Comparator condition codes, also decoded by the ID stage.
    typedef enum logic [1:0] {
        BR_EQ = 2'b00,
        BR_GT = 2'b01,
        BR_LT = 2'b10
    } branch_code_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_target_calc.sv
// ============================================================================
//  Module      : branch_target_calc
//  Description : PC-relative branch target: idPC + 2 + sext(offset) * 2.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_target_calc
    import cpu_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic [PC_W-1:0] idPC,
    input  logic [7:0]      branchOffset,
    output logic [PC_W-1:0] target
);

    logic [PC_W-1:0] w_offset_bytes;

    assign w_offset_bytes = {{(PC_W-9){branchOffset[7]}}, branchOffset, 1'b0};
    assign target         = idPC + PC_W'(INSTR_BYTES) + w_offset_bytes;

endmodule

`default_nettype wire

// File: rtl/pc_branch_unit.sv
// ============================================================================
//  Module      : pc_branch_unit
//  Description : PC owner, branch/jump redirect, counted IF/ID flush, halt.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_branch_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W         = 16,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int              FLUSH_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branchEn,
    input  logic            branch,
    input  logic [7:0]      branchOffset,
    input  logic [PC_W-1:0] idPC,
    input  logic            jumpEn,
    input  logic [PC_W-1:0] jumpTarget,
    input  logic            halt,
    output logic [PC_W-1:0] pc,
    output logic            flushIFID,
    output logic            branchTaken,
    output logic            halted,
    output logic [15:0]     takenCount
);

    localparam logic [1:0]      c_flush_init = 2'(FLUSH_CYCLES);
    localparam logic [PC_W-1:0] c_pc_step    = PC_W'(INSTR_BYTES);

    pc_state_t       r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc, w_pc_nxt;
    logic [1:0]      r_flush_cnt, w_flush_cnt_nxt;
    logic            r_flush, w_flush_nxt;
    logic            r_taken, w_taken_nxt;
    logic            r_halted, w_halted_nxt;
    logic [15:0]     r_taken_count, w_taken_count_nxt;
    logic [PC_W-1:0] w_branch_target;
    logic [PC_W-1:0] w_jump_target;
    logic            w_redirect;

    branch_target_calc #(
        .PC_W (PC_W)
    ) u_target (
        .idPC         (idPC),
        .branchOffset (branchOffset),
        .target       (w_branch_target)
    );

    assign w_jump_target = jumpTarget & ~PC_W'(1);

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_flush_cnt_nxt   = r_flush_cnt;
        w_flush_nxt       = r_flush;
        w_taken_nxt       = 1'b0;
        w_halted_nxt      = r_halted;
        w_taken_count_nxt = r_taken_count;
        w_redirect        = 1'b0;

        if (!stall) begin
            case (r_state)
                ST_RUN: begin
                    // Halt outranks any redirect; branch outranks jump.
                    if (halt) begin
                        w_state_nxt  = ST_HALT;
                        w_halted_nxt = 1'b1;
                    end else if (branchEn && branch) begin
                        w_pc_nxt   = w_branch_target;
                        w_redirect = 1'b1;
                    end else if (jumpEn) begin
                        w_pc_nxt   = w_jump_target;
                        w_redirect = 1'b1;
                    end else begin
                        w_pc_nxt = r_pc + c_pc_step;
                    end
                end
                ST_FLUSH: begin
                    w_pc_nxt        = r_pc + c_pc_step;
                    w_flush_cnt_nxt = r_flush_cnt - 2'd1;
                    if (r_flush_cnt <= 2'd1) begin
                        w_state_nxt = ST_RUN;
                        w_flush_nxt = 1'b0;
                    end
                end
                ST_HALT: begin
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase

            if (w_redirect) begin
                w_state_nxt       = ST_FLUSH;
                w_flush_cnt_nxt   = c_flush_init;
                w_flush_nxt       = 1'b1;
                w_taken_nxt       = 1'b1;
                w_taken_count_nxt = sat_inc16(r_taken_count);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_flush_cnt   <= 2'd0;
            r_flush       <= 1'b0;
            r_taken       <= 1'b0;
            r_halted      <= 1'b0;
            r_taken_count <= 16'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_flush_cnt   <= w_flush_cnt_nxt;
            r_flush       <= w_flush_nxt;
            r_taken       <= w_taken_nxt;
            r_halted      <= w_halted_nxt;
            r_taken_count <= w_taken_count_nxt;
        end
    end

    assign pc          = r_pc;
    assign flushIFID   = r_flush;
    assign branchTaken = r_taken;
    assign halted      = r_halted;
    assign takenCount  = r_taken_count;

endmodule

`default_nettype wire
